// File: rtl/mem_pkg.sv
// Shared definitions for the 128x16 SRAM subsystem: geometry constants and
// the controller state encoding, used by sram, sram_ctrl and the cache.
package mem_pkg;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 128;
    localparam int LEN_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_ERR  = 2'd3
    } mem_state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Burst sequencer for the single-port SRAM. Accepts 1-4 word read/write
// requests, walks the SRAM pins beat by beat and returns read words through
// a registered stage with a one-cycle rvalid strobe.
module sram_ctrl
    import mem_pkg::*;
#(
    parameter int AW    = mem_pkg::AW,
    parameter int DW    = mem_pkg::DW,
    parameter int DEPTH = mem_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [DW-1:0]    wdata,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    output logic [DW-1:0]    rdata,
    output logic             rvalid,
    output logic             done,
    output logic             err,
    output logic [AW-1:0]    sram_addr,
    output logic [DW-1:0]    sram_din,
    output logic             sram_we,
    input  logic [DW-1:0]    sram_dout
);

    mem_state_t       state, state_nxt;
    logic [AW-1:0]    cur;
    logic [LEN_W-1:0] left;
    logic             accept;
    logic             beat;
    logic             last_beat;

    // Burst address advance: wraps modulo DEPTH so the top bit never sets.
    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        if (a == AW'(DEPTH - 1))
            return '0;
        return a + AW'(1);
    endfunction

    assign accept    = req_valid && req_ready;
    assign last_beat = beat && (left == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state, handshake signals and SRAM pin drive.
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        sram_addr   = '0;
        sram_din    = '0;
        sram_we     = 1'b0;
        beat        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    if (req_addr >= AW'(DEPTH))
                        state_nxt = ST_ERR;
                    else if (req_we)
                        state_nxt = ST_WR;
                    else
                        state_nxt = ST_RD;
                end
            end
            ST_WR: begin
                wdata_ready = 1'b1;
                sram_addr   = cur;
                sram_din    = wdata;
                sram_we     = wdata_valid;
                beat        = wdata_valid;
                if (wdata_valid && (left == '0))
                    state_nxt = ST_IDLE;
            end
            ST_RD: begin
                sram_addr = cur;
                beat      = 1'b1;
                if (left == '0)
                    state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst address and remaining-beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= '0;
            left <= '0;
        end else if (accept) begin
            cur  <= req_addr;
            left <= req_len;
        end else if (beat) begin
            cur  <= addr_inc(cur);
            left <= left - LEN_W'(1);
        end
    end

    // ---- read-return stage: SRAM output registered, status pulses ----
    // Read-data capture plus one-cycle rvalid/done/err strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            done   <= last_beat;
            err    <= (state == ST_ERR);
            if (state == ST_RD) begin
                rdata  <= sram_dout;
                rvalid <= 1'b1;
            end
        end
    end

endmodule
